// File: rtl/round_key_sequencer.sv
// round_key_sequencer: walks the eleven round keys produced by a key generator
// and presents them one at a time, registered, to a cipher datapath with a
// valid/ack handshake.
// Optional feature: define RKS_DECRYPT_EN to support descending key order
// (10..0) selected by the decrypt input. Without it, the order is always
// ascending (0..10) and decrypt is ignored.
module round_key_sequencer (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic         decrypt,
  input  logic         generation_done,
  input  logic [127:0] round_key_0,
  input  logic [127:0] round_key_x,
  input  logic         key_ack,
  output logic [3:0]   read_addr,
  output logic [127:0] key_out,
  output logic         key_valid,
  output logic [3:0]   round_num,
  output logic         last_key,
  output logic         busy,
  output logic         seq_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_GEN,
    S_FETCH,
    S_PRESENT,
    S_DONE
  } state_e;

  localparam logic [3:0] IDX_LOW  = 4'd0;
  localparam logic [3:0] IDX_HIGH = 4'd10;

  state_e         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [127:0]   key_q, key_d;
  logic           valid_q, valid_d;
  logic [3:0]     rnum_q, rnum_d;

  // Index bookkeeping that depends on the key order.
  logic [3:0]     start_idx;   // first index chosen from the decrypt input at start
  logic [3:0]     first_idx;   // first index of the sequence in progress
  logic [3:0]     final_idx;   // final index of the sequence in progress
  logic [3:0]     next_idx;    // index following idx_q in the sequence order

`ifdef RKS_DECRYPT_EN
  logic desc_q, desc_d;

  assign start_idx = decrypt ? IDX_HIGH : IDX_LOW;
  assign first_idx = desc_q  ? IDX_HIGH : IDX_LOW;
  assign final_idx = desc_q  ? IDX_LOW  : IDX_HIGH;
  assign next_idx  = desc_q  ? (idx_q - 4'd1) : (idx_q + 4'd1);

  // Order latch: captured with start, held for the whole sequence.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) desc_q <= 1'b0;
    else        desc_q <= desc_d;
  end
`else
  logic unused_decrypt;

  assign unused_decrypt = decrypt;
  assign start_idx      = IDX_LOW;
  assign first_idx      = IDX_LOW;
  assign final_idx      = IDX_HIGH;
  assign next_idx       = idx_q + 4'd1;
`endif

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      idx_q   <= IDX_LOW;
      key_q   <= '0;
      valid_q <= 1'b0;
      rnum_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      rnum_q  <= rnum_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    key_d   = key_q;
    valid_d = valid_q;
    rnum_d  = rnum_q;
`ifdef RKS_DECRYPT_EN
    desc_d  = desc_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef RKS_DECRYPT_EN
          desc_d  = decrypt;
`endif
          idx_d   = start_idx;
          state_d = generation_done ? S_FETCH : S_WAIT_GEN;
        end
      end
      S_WAIT_GEN: begin
        if (generation_done) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (!generation_done) begin
          // Keys vanished under us: restart the sequence from the top.
          idx_d   = first_idx;
          state_d = S_WAIT_GEN;
        end else begin
          key_d   = (idx_q == IDX_LOW) ? round_key_0 : round_key_x;
          valid_d = 1'b1;
          rnum_d  = idx_q;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (!generation_done) begin
          valid_d = 1'b0;
          idx_d   = first_idx;
          state_d = S_WAIT_GEN;
        end else if (key_ack) begin
          valid_d = 1'b0;
          if (idx_q == final_idx) begin
            state_d = S_DONE;
          end else begin
            idx_d   = next_idx;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the state and output registers.
  always_comb begin
    busy      = (state_q != S_IDLE);
    seq_done  = (state_q == S_DONE);
    read_addr = (state_q == S_IDLE) ? 4'd0 : idx_q;
    last_key  = valid_q && (rnum_q == final_idx);
  end

  assign key_out   = key_q;
  assign key_valid = valid_q;
  assign round_num = rnum_q;

endmodule
